// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and command handshake bundle for uart_cmd_ctrl.
// master = byte source / command consumer side, slave = the controller.
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        err_chk;
    logic        err_cmd;
    logic        err_timeout;
    logic        err_overrun;
    logic [7:0]  err_count;
    logic        busy;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  err_chk, err_cmd, err_timeout, err_overrun, err_count, busy
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output err_chk, err_cmd, err_timeout, err_overrun, err_count, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command frame parser: SYNC, OPCODE, ADDR, DATA_H, DATA_L[, CHK] -> one command.
// Define UART_CMD_CHKSUM_EN to include the CHK byte and its XOR check.
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        SYNC_WAIT,
        GET_OP,
        GET_ADDR,
        GET_DH,
        GET_DL,
`ifdef UART_CMD_CHKSUM_EN
        GET_CHK,
`endif
        ISSUE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  op_q, op_d, addr_q, addr_d, dh_q, dh_d;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  dl_q, dl_d;
    logic        err_chk_c;
`endif
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        err_cmd_c, err_to_c, err_ovr_c, err_any;
    logic        in_get, issue;
    logic [7:0]  dl_src;

    function automatic logic op_legal(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        op_d        = op_q;
        addr_d      = addr_q;
        dh_d        = dh_q;
`ifdef UART_CMD_CHKSUM_EN
        dl_d        = dl_q;
        err_chk_c   = 1'b0;
`endif
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_cmd_c   = 1'b0;
        err_to_c    = 1'b0;
        err_ovr_c   = 1'b0;
        issue       = 1'b0;
        dl_src      = '0;
        in_get      = (state_q != SYNC_WAIT) && (state_q != ISSUE);

        // A byte arriving on the expiry cycle wins over the timeout.
        if (in_get) begin
            cnt_d = bus.rx_valid ? '0 : cnt_q + 16'd1;
            if (!bus.rx_valid && cnt_q == TO_LAST) begin
                err_to_c = 1'b1;
                state_d  = SYNC_WAIT;
            end
        end

        case (state_q)
            SYNC_WAIT: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = GET_OP;
            GET_OP:    if (bus.rx_valid) begin op_d   = bus.rx_data; state_d = GET_ADDR; end
            GET_ADDR:  if (bus.rx_valid) begin addr_d = bus.rx_data; state_d = GET_DH;   end
            GET_DH:    if (bus.rx_valid) begin dh_d   = bus.rx_data; state_d = GET_DL;   end
`ifdef UART_CMD_CHKSUM_EN
            GET_DL:    if (bus.rx_valid) begin dl_d   = bus.rx_data; state_d = GET_CHK;  end
            GET_CHK: begin
                if (bus.rx_valid) begin
                    if ((op_q ^ addr_q ^ dh_q ^ dl_q) != bus.rx_data) begin
                        err_chk_c = 1'b1;
                        state_d   = SYNC_WAIT;
                    end else if (!op_legal(op_q)) begin
                        err_cmd_c = 1'b1;
                        state_d   = SYNC_WAIT;
                    end else begin
                        issue  = 1'b1;
                        dl_src = dl_q;
                    end
                end
            end
`else
            GET_DL: begin
                if (bus.rx_valid) begin
                    if (!op_legal(op_q)) begin
                        err_cmd_c = 1'b1;
                        state_d   = SYNC_WAIT;
                    end else begin
                        issue  = 1'b1;
                        dl_src = bus.rx_data;
                    end
                end
            end
`endif
            ISSUE: begin
                err_ovr_c = bus.rx_valid;
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = SYNC_WAIT;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase

        if (issue) begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
            cmd_wr_d    = (op_q == 8'h01);
            cmd_addr_d  = addr_q;
            cmd_wdata_d = (op_q == 8'h01) ? {dh_q, dl_src} : '0;
        end

`ifdef UART_CMD_CHKSUM_EN
        err_any = err_chk_c | err_cmd_c | err_to_c | err_ovr_c;
`else
        err_any = err_cmd_c | err_to_c | err_ovr_c;
`endif
        err_count_d = (err_any && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC_WAIT;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            dh_q        <= '0;
`ifdef UART_CMD_CHKSUM_EN
            dl_q        <= '0;
`endif
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
`ifdef UART_CMD_CHKSUM_EN
            dl_q        <= dl_d;
`endif
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_count_q <= err_count_d;
        end
    end

    // Error pulses are combinational on the offending cycle; masked while in reset.
`ifdef UART_CMD_CHKSUM_EN
    assign bus.err_chk     = err_chk_c & ~rst;
`else
    assign bus.err_chk     = 1'b0;
`endif
    assign bus.err_cmd     = err_cmd_c & ~rst;
    assign bus.err_timeout = err_to_c  & ~rst;
    assign bus.err_overrun = err_ovr_c & ~rst;
    assign bus.err_count   = err_count_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_wr      = cmd_wr_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.cmd_wdata   = cmd_wdata_q;
    assign bus.busy        = (state_q != SYNC_WAIT);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame table, directed corner sequences,
// and random byte streams compared cycle-by-cycle against a queue-based frame model.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 2000;
`ifdef UART_CMD_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int NPAY = CHK_EN ? 5 : 4;

    localparam int OUT_ISSUE = 0;
    localparam int OUT_CHK   = 1;
    localparam int OUT_CMD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the frame in progress, idle-cycle count, pending command.
    bit          m_known = 1'b0, m_inframe = 1'b0, m_pend = 1'b0;
    logic [7:0]  m_q[$];
    int          m_idle = 0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_wdata = '0;
    int          m_errcnt = 0;

    int          o_chk, o_cmd, o_to, o_ovr, o_valid;
    logic        o_wr;
    logic [7:0]  o_addr;
    logic [15:0] o_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        o_chk = 0; o_cmd = 0; o_to = 0; o_ovr = 0; o_valid = 0;
        o_wr = 1'b0; o_addr = '0; o_wdata = '0;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        bit e_chk, e_cmd, e_to, e_ovr;
        logic [7:0] x;
        e_chk = 0; e_cmd = 0; e_to = 0; e_ovr = 0;
        rst = r; bus.rx_valid = v; bus.rx_data = d; bus.cmd_ready = rdy;
        @(negedge clk);
        if (m_known) begin
            chk("cmd_valid", 64'(bus.cmd_valid), 64'(m_pend));
            chk("busy", 64'(bus.busy), 64'(m_inframe || m_pend));
            chk("err_count", 64'(bus.err_count), 64'(m_errcnt));
            chk("cmd_fields", {39'd0, bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata},
                {39'd0, m_wr, m_addr, m_wdata});
        end
        if (!r) begin
            if (m_pend) begin
                e_ovr = v;
                if (rdy) m_pend = 1'b0;
            end else if (m_inframe) begin
                if (v) begin
                    m_q.push_back(d);
                    m_idle = 0;
                    if (m_q.size() == NPAY) begin
                        x = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3];
                        if (CHK_EN && x != m_q[NPAY-1]) e_chk = 1;
                        else if (m_q[0] != 8'h01 && m_q[0] != 8'h02) e_cmd = 1;
                        else begin
                            m_pend  = 1'b1;
                            m_wr    = (m_q[0] == 8'h01);
                            m_addr  = m_q[1];
                            m_wdata = m_wr ? {m_q[2], m_q[3]} : 16'h0000;
                        end
                        m_inframe = 1'b0;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin
                        e_to = 1;
                        m_inframe = 1'b0;
                    end
                end
            end else if (v && d == SYNC) begin
                m_inframe = 1'b1;
                m_q.delete();
                m_idle = 0;
            end
        end
        if (m_known || r)
            chk("err_pulses", {60'd0, bus.err_chk, bus.err_cmd, bus.err_timeout, bus.err_overrun},
                {60'd0, e_chk, e_cmd, e_to, e_ovr});
        if (bus.err_chk === 1'b1) o_chk++;
        if (bus.err_cmd === 1'b1) o_cmd++;
        if (bus.err_timeout === 1'b1) o_to++;
        if (bus.err_overrun === 1'b1) o_ovr++;
        if (bus.cmd_valid === 1'b1) begin
            o_valid++; o_wr = bus.cmd_wr; o_addr = bus.cmd_addr; o_wdata = bus.cmd_wdata;
        end
        if (r) begin
            m_known = 1'b1; m_inframe = 1'b0; m_pend = 1'b0; m_q.delete(); m_idle = 0;
            m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_errcnt = 0;
        end else if ((e_chk || e_cmd || e_to || e_ovr) && m_errcnt < 255) begin
            m_errcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck, input bit rdy,
                              input int gap);
        logic [7:0] b[6];
        b = '{SYNC, op, addr, dh, dl, ck};
        for (int i = 0; i < NPAY + 1; i++) step(1'b0, 1'b1, b[i], rdy);
        repeat (gap) step(1'b0, 1'b0, 8'h00, rdy);
    endtask

    typedef struct {
        logic [7:0]  op, addr, dh, dl, ck;
        int          out_chk, out_nochk;
        logic        wr;
        logic [15:0] wdata;
    } frame_vec_t;

    frame_vec_t vecs[8];

    initial begin
        int out;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.cmd_ready = 1'b1;

        vecs[0] = '{8'h01, 8'h10, 8'h12, 8'h34, 8'h37, OUT_ISSUE, OUT_ISSUE, 1'b1, 16'h1234};
        vecs[1] = '{8'h02, 8'h20, 8'h00, 8'h00, 8'hFF, OUT_CHK,   OUT_ISSUE, 1'b0, 16'h0000};
        vecs[2] = '{8'h03, 8'h20, 8'h00, 8'h00, 8'h23, OUT_CMD,   OUT_CMD,   1'b0, 16'h0000};
        vecs[3] = '{8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA7, OUT_ISSUE, OUT_ISSUE, 1'b0, 16'h0000};
        vecs[4] = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFE, OUT_ISSUE, OUT_ISSUE, 1'b1, 16'hFFFF};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, OUT_CMD,   OUT_CMD,   1'b0, 16'h0000};
        vecs[6] = '{8'h01, 8'h33, 8'h44, 8'h55, 8'h00, OUT_CHK,   OUT_ISSUE, 1'b1, 16'h4455};
        vecs[7] = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h05, OUT_CHK,   OUT_CMD,   1'b0, 16'h0000};

        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("reset_state", {43'd0, bus.busy, bus.cmd_valid, bus.cmd_wr, bus.err_count, bus.cmd_addr},
            64'd0);
        chk("reset_wdata", 64'(bus.cmd_wdata), 64'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 8; i++) begin
            out = CHK_EN ? vecs[i].out_chk : vecs[i].out_nochk;
            clear_obs();
            send_frame(vecs[i].op, vecs[i].addr, vecs[i].dh, vecs[i].dl, vecs[i].ck, 1'b1, 3);
            chk($sformatf("vec%0d_valid_cycles", i), 64'(o_valid), 64'(out == OUT_ISSUE));
            chk($sformatf("vec%0d_err_chk", i), 64'(o_chk), 64'(out == OUT_CHK));
            chk($sformatf("vec%0d_err_cmd", i), 64'(o_cmd), 64'(out == OUT_CMD));
            if (out == OUT_ISSUE)
                chk($sformatf("vec%0d_cmd", i), {39'd0, o_wr, o_addr, o_wdata},
                    {39'd0, vecs[i].wr, vecs[i].addr, vecs[i].wdata});
        end

        // Held command, overrun while waiting and on the accept cycle.
        clear_obs();
        send_frame(8'h02, 8'h44, 8'h00, 8'h00, 8'h46, 1'b0, 100);
        chk("hold_valid_cycles", 64'(o_valid), 64'd100);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        chk("overrun_pulse", 64'(o_ovr), 64'd1);
        chk("hold_cmd_stable", {39'd0, bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata}, {39'd0, 1'b0, 8'h44, 16'h0000});
        step(1'b0, 1'b1, 8'h33, 1'b1);
        chk("overrun_on_accept", 64'(o_ovr), 64'd2);
        chk("after_accept_idle", {62'd0, bus.busy, bus.cmd_valid}, 64'd0);

        // Timeout exactly on the TO-th idle cycle.
        clear_obs();
        step(1'b0, 1'b1, SYNC, 1'b1); step(1'b0, 1'b1, 8'h01, 1'b1); step(1'b0, 1'b1, 8'h10, 1'b1);
        repeat (TO - 1) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("timeout_not_early", 64'(o_to), 64'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("timeout_pulse", 64'(o_to), 64'd1);
        chk("timeout_to_idle", 64'(bus.busy), 64'd0);
        clear_obs();
        send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 1'b1, 2);
        chk("post_timeout_frame", 64'(o_valid), 64'd1);

        // Byte coinciding with expiry keeps the frame alive.
        clear_obs();
        step(1'b0, 1'b1, SYNC, 1'b1);
        repeat (TO - 1) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b1); step(1'b0, 1'b1, 8'h10, 1'b1);
        step(1'b0, 1'b1, 8'h12, 1'b1); step(1'b0, 1'b1, 8'h34, 1'b1);
        if (CHK_EN) step(1'b0, 1'b1, 8'h37, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("expiry_byte_wins_to", 64'(o_to), 64'd0);
        chk("expiry_byte_wins_cmd", 64'(o_valid), 64'd1);

        // Reset mid-frame and during ISSUE.
        clear_obs();
        step(1'b0, 1'b1, SYNC, 1'b1); step(1'b0, 1'b1, 8'h01, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("midframe_reset_busy", 64'(bus.busy), 64'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("midframe_reset_no_err", 64'(o_chk + o_cmd + o_to + o_ovr), 64'd0);
        clear_obs();
        send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 1'b1, 2);
        chk("post_reset_frame", {39'd0, o_wr, o_addr, o_wdata}, {39'd0, 1'b1, 8'h10, 16'h1234});
        send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 1'b0, 3);
        clear_obs();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("issue_reset", {61'd0, bus.cmd_valid, bus.busy, bus.err_count == 8'd0}, 64'd1);

        // err_count saturation through back-to-back overruns.
        send_frame(8'h02, 8'h01, 8'h00, 8'h00, 8'h03, 1'b0, 0);
        repeat (270) step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("err_count_saturated", 64'(bus.err_count), 64'd255);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random streams against the model.
        for (int it = 0; it < 400; it++) begin
            logic [7:0] b[6];
            int long_idx, g;
            if ($urandom_range(0, 49) == 0) begin
                step(1'b1, 1'b0, 8'h00, 1'b1);
                continue;
            end
            if ($urandom_range(0, 9) == 0) begin
                step(1'b0, 1'b1, 8'($urandom), $urandom_range(0, 3) != 0);
                continue;
            end
            b[0] = SYNC;
            case ($urandom_range(0, 3))
                0, 1:    b[1] = 8'h01;
                2:       b[1] = 8'h02;
                default: b[1] = 8'($urandom);
            endcase
            b[2] = 8'($urandom); b[3] = 8'($urandom); b[4] = 8'($urandom);
            b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
            if ($urandom_range(0, 3) == 0) b[5] = b[5] ^ 8'($urandom_range(1, 255));
            long_idx = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1;
            for (int i = 0; i < NPAY + 1; i++) begin
                step(1'b0, 1'b1, b[i], $urandom_range(0, 3) != 0);
                g = (i == long_idx) ? TO - 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
                repeat (g) step(1'b0, 1'b0, 8'h00, $urandom_range(0, 3) != 0);
            end
        end
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 50000: inter-byte timeout in clk cycles (1 ms at 50 MHz); legal range 1..65535.
REQ-003 clk  input  1  50 MHz system clock; one clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 cmd_valid  output  1  command pending; held until accepted.
REQ-008 cmd_ready  input  1  consumer accepts the command when cmd_valid=1 and cmd_ready=1.
REQ-009 cmd_wr  output  1  1 = write command (opcode 0x01), 0 = read command (opcode 0x02).
REQ-010 cmd_addr  output  8  register address.
REQ-011 cmd_wdata  output  16  write data, {DATA_H, DATA_L}; 0 for reads.
REQ-012 err_chk, err_cmd, err_timeout, err_overrun  output  1 each  one-cycle error pulses.
REQ-013 err_count  output  8  count of all error pulses, saturating at 255.
REQ-014 busy  output  1  high in any state other than SYNC_WAIT.

Function
REQ-015 Frame format SHALL be SYNC, OPCODE, ADDR, DATA_H, DATA_L, CHK; CHK = XOR of OPCODE..DATA_L.
REQ-016 States SHALL be SYNC_WAIT, GET_OP, GET_ADDR, GET_DH, GET_DL, GET_CHK, ISSUE.
REQ-017 SYNC_WAIT: rx_valid with rx_data==SYNC_BYTE -> GET_OP; other bytes are discarded silently.
REQ-018 Each GET_* state SHALL advance on rx_valid only; it captures the byte into a shadow register, and the shadow is never copied to cmd_* outputs before ISSUE.
REQ-019 A SYNC_BYTE value received mid-frame SHALL be treated as data (no resynchronisation).
REQ-020 GET_CHK: a matching checksum with a legal opcode -> ISSUE; a bad checksum -> err_chk pulse, SYNC_WAIT; an illegal opcode (checksum good) -> err_cmd pulse, SYNC_WAIT; checksum error takes priority over opcode error.
REQ-021 cmd_valid and cmd_* outputs SHALL update on the clock edge after the CHK byte's rx_valid (latency 1 cycle); cmd_* stay stable while cmd_valid=1.
REQ-022 ISSUE: on cmd_valid & cmd_ready -> cmd_valid=0 next cycle, SYNC_WAIT; accept with cmd_ready already high takes exactly 1 cycle in ISSUE.
REQ-023 Any rx_valid during ISSUE, including the accept cycle, SHALL be dropped and pulse err_overrun.
REQ-024 The 16-bit timeout counter SHALL clear on entry to GET_OP and on every rx_valid, and increment each cycle in GET_* states.
REQ-025 When the counter reaches TIMEOUT_CLKS-1 with no rx_valid that cycle: err_timeout pulse, SYNC_WAIT; if rx_valid coincides with expiry, the byte wins and no timeout occurs.
REQ-026 No timeout SHALL apply in SYNC_WAIT or ISSUE.
REQ-027 err_count SHALL increment by 1 per cycle in which any err_* pulse is high; two pulses never occur in the same cycle.

Reset
REQ-028 While rst=1 on a clk edge: state=SYNC_WAIT; cmd_valid=0; cmd_wr=0; cmd_addr=0; cmd_wdata=0; all err_*=0; err_count=0; busy=0; timeout counter=0; shadows=0.
REQ-029 Reset asserted mid-frame or in ISSUE SHALL abandon the frame with no error pulse; the first frame after reset deasserts SHALL parse normally.

Configuration
REQ-030 Macro UART_CMD_CHKSUM_EN defined: frame is 6 bytes and the checksum is checked per REQ-020.
REQ-031 UART_CMD_CHKSUM_EN undefined: the GET_CHK state is absent; opcode validation happens after DATA_L, which then leads to ISSUE or err_cmd; err_chk is tied to 0.

Verification (UART_CMD_CHKSUM_EN defined unless stated)
REQ-032 Send A5 01 10 12 34 37, cmd_ready=1 -> one cycle with cmd_valid=1, cmd_wr=1, cmd_addr=10, cmd_wdata=1234; err_count=0.
REQ-033 Send A5 02 20 00 00 FF -> no cmd_valid; err_chk one pulse; err_count=1. Then send A5 03 20 00 00 23 -> err_cmd pulse; err_count=2.
REQ-034 Send A5 01 10, then idle 50000 cycles -> err_timeout pulse on the 50000th idle cycle; the next good frame is accepted.
REQ-035 Good read frame with cmd_ready=0 for 100 cycles, then a byte 55 arrives -> err_overrun, cmd_* stable; cmd_ready=1 -> accepted, SYNC_WAIT.
REQ-036 Assert rst after A5 01 -> busy=0, no error pulse; build without UART_CMD_CHKSUM_EN, send A5 01 10 12 34 -> write command issued.
